ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It is the outbound counterpart of the keyboard receive path and sends command bytes to the keyboard, such as 0xED to set the LEDs or 0xFF to reset.
- Drives PS2Clk/PS2Data as open-drain through active-high pull-low enables.
- The top level builds the tri-states. The receiver must ignore line activity while busy=1.

---
 rtl/ps2_host_tx.sv | 151 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, clocks a byte out on
// device falling edges, then checks the device ack. Lines are open-drain pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done_tick,
  output logic       err_tick,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int MAXA = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int MAXC = (MAXA > SETUP_CYCLES) ? MAXA : SETUP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RTS, S_REQ, S_START, S_DATA, S_ACK, S_WAIT
  } state_t;

  state_t                r_state, w_nstate;
  logic [1:0]            r_csync, r_dsync;
  logic [FILTER_LEN-1:0] r_cfilt, r_dfilt;
  logic                  r_fclk, r_fdat;
  logic [9:0]            r_shift;
  logic [3:0]            r_bitcnt;
  logic [CW-1:0]         r_cnt;
  logic                  r_dbit, r_ack_ok;

  logic w_fall, w_tmo_active, w_timeout, w_cnt_clr;
  logic w_c_oe, w_d_oe, w_done, w_err;

  assign w_fall       = r_fclk & ~|r_cfilt;
  assign w_tmo_active = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_ACK)   || (r_state == S_WAIT);
  // A device edge in the same cycle wins over the timeout.
  assign w_timeout    = w_tmo_active && !w_fall && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_nstate  = r_state;
    w_c_oe    = 1'b0;
    w_d_oe    = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      S_IDLE: if (wr_en) begin
        w_nstate  = S_RTS;
        w_cnt_clr = 1'b1;
      end
      S_RTS: begin
        w_c_oe = 1'b1;
        if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
          w_nstate  = S_REQ;
          w_cnt_clr = 1'b1;
        end
      end
      S_REQ: begin
        w_c_oe = 1'b1;
        w_d_oe = 1'b1;
        if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
          w_nstate  = S_START;
          w_cnt_clr = 1'b1;
        end
      end
      S_START: begin
        w_d_oe = 1'b1;
        if (w_fall) w_nstate = S_DATA;
      end
      S_DATA: begin
        w_d_oe = r_dbit;
        // bit_cnt 8 on this edge means the stop bit is being presented
        if (w_fall && r_bitcnt == 4'd8) w_nstate = S_ACK;
      end
      S_ACK: if (w_fall) w_nstate = S_WAIT;
      S_WAIT: if (r_fclk && r_fdat) begin
        w_nstate = S_IDLE;
        w_done   = r_ack_ok;
        w_err    = ~r_ack_ok;
      end
      default: w_nstate = S_IDLE;
    endcase
    if (w_timeout) begin
      w_nstate = S_IDLE;
      w_c_oe   = 1'b0;
      w_d_oe   = 1'b0;
      w_done   = 1'b0;
      w_err    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csync  <= '1;
      r_dsync  <= '1;
      r_cfilt  <= '1;
      r_dfilt  <= '1;
      r_fclk   <= 1'b1;
      r_fdat   <= 1'b1;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_cnt    <= '0;
      r_dbit   <= 1'b0;
      r_ack_ok <= 1'b0;
    end else begin
      r_csync <= {r_csync[0], ps2c_in};
      r_dsync <= {r_dsync[0], ps2d_in};
      r_cfilt <= {r_cfilt[FILTER_LEN-2:0], r_csync[1]};
      r_dfilt <= {r_dfilt[FILTER_LEN-2:0], r_dsync[1]};
      if (&r_cfilt)       r_fclk <= 1'b1;
      else if (~|r_cfilt) r_fclk <= 1'b0;
      if (&r_dfilt)       r_fdat <= 1'b1;
      else if (~|r_dfilt) r_fdat <= 1'b0;

      // Our own RTS pull drags the filtered clock low, so edges only count once the device clocks.
      if (w_cnt_clr || (w_tmo_active && w_fall)) r_cnt <= '0;
      else if (r_state != S_IDLE)                r_cnt <= r_cnt + 1'b1;

      if (r_state == S_IDLE && wr_en) begin
        r_shift <= {1'b1, ~^din, din};
      end else if (w_fall && (r_state == S_START || r_state == S_DATA)) begin
        r_dbit   <= ~r_shift[0];
        r_shift  <= {1'b0, r_shift[9:1]};
        r_bitcnt <= (r_state == S_START) ? 4'd0 : r_bitcnt + 4'd1;
      end

      if (r_state == S_ACK && w_fall) r_ack_ok <= ~r_fdat;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done_tick = w_done;
  assign err_tick  = w_err;
  assign ps2c_oe   = w_c_oe;
  assign ps2d_oe   = w_d_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and compares them, and the completion pulses, against a frame-level model.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int SET  = 4;
  localparam int FL   = 4;
  localparam int TO   = 5000;
  localparam int HALF = 200;

  logic       clk = 1'b0;
  logic       reset, wr_en;
  logic [7:0] din;
  logic       busy, done_tick, err_tick, ps2c_oe, ps2d_oe;
  logic       ps2c_in, ps2d_in;
  logic       dev_c, dev_d;

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_done, n_err, n_rts, n_req, err_cyc;
  logic [1:0] err_oe;

  assign ps2c_in = ~(ps2c_oe | dev_c);
  assign ps2d_in = ~(ps2d_oe | dev_d);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .FILTER_LEN(FL),
                .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .busy(busy),
    .done_tick(done_tick), .err_tick(err_tick), .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_tick) n_done++;
    if (err_tick) begin
      n_err++;
      err_cyc = cyc;
      err_oe  = {ps2c_oe, ps2d_oe};
    end
    if (done_tick || err_tick) chk("excl", 32'(done_tick & err_tick), 0);
    if (ps2c_oe && !ps2d_oe) n_rts++;
    if (ps2c_oe && ps2d_oe)  n_req++;
  end

  // Frame as the device should see it: start 0, d0..d7, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic clr();
    n_done = 0; n_err = 0; n_rts = 0; n_req = 0; err_cyc = 0; err_oe = 2'b11;
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1 wr_en = 1'b1; din = d;
    @(negedge clk); chk("busy_pre", 32'(busy), 0);
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk); chk("busy_acc", 32'(busy), 1);
  endtask

  task automatic dev_frame(input int npulses, input bit ack, output logic [10:0] bits,
                           output int last_fall, output int last_rise);
    int t;
    bits = '1; t = 0; last_fall = 0; last_rise = 0;
    while (!ps2c_oe && t < 2000) begin @(negedge clk); t++; end
    while (ps2c_oe && t < 2000) begin @(negedge clk); t++; end
    chk("rts_wait", 32'(t < 2000), 1);
    bits[0] = ps2d_in;
    for (int p = 1; p <= npulses; p++) begin
      repeat (HALF) @(posedge clk);
      #1 dev_c = 1'b1; last_fall = cyc;
      repeat (HALF) @(posedge clk);
      #1 dev_c = 1'b0; last_rise = cyc;
      if (p <= 10) bits[p] = ps2d_in;
      if (p == 10 && ack) dev_d = 1'b1;
    end
    dev_d = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    chk("idle", 32'(busy), 0);
  endtask

  task automatic run_byte(input logic [7:0] d, input bit ack);
    logic [10:0] bits;
    int lf, lr;
    clr();
    send(d);
    dev_frame(11, ack, bits, lf, lr);
    wait_idle();
    chk($sformatf("frame_%02h", d), 32'(bits), 32'(exp_frame(d)));
    chk("n_done", n_done, ack ? 1 : 0);
    chk("n_err", n_err, ack ? 0 : 1);
    if (!ack) chk("err_after_idle", 32'(err_cyc > lr), 1);
  endtask

  initial begin
    logic [10:0] bits;
    int lf, lr, t;
    reset = 1'b1; wr_en = 1'b0; din = 8'h00; dev_c = 1'b0; dev_d = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {busy, done_tick, err_tick, ps2c_oe, ps2d_oe}, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("idle_state", {busy, done_tick, err_tick, ps2c_oe, ps2d_oe}, 0);

    // Basic command byte with RTS/setup timing
    clr();
    send(8'hED);
    dev_frame(11, 1'b1, bits, lf, lr);
    wait_idle();
    chk("frame_ED", 32'(bits), 32'(exp_frame(8'hED)));
    chk("rts_len", n_rts, INH);
    chk("req_len", n_req, SET);
    chk("ed_done", n_done, 1);
    chk("ed_err", n_err, 0);

    run_byte(8'h00, 1'b1);
    run_byte(8'h01, 1'b1);
    run_byte(8'hFF, 1'b1);
    run_byte(8'hA5, 1'b0);
    repeat (3) run_byte(8'($urandom), $urandom_range(0, 3) != 0);

    // wr_en while busy is ignored
    clr();
    send(8'hED);
    repeat (20) @(posedge clk);
    #1 wr_en = 1'b1; din = 8'h55;
    @(posedge clk); #1 wr_en = 1'b0; din = 8'h00;
    dev_frame(11, 1'b1, bits, lf, lr);
    wait_idle();
    chk("frame_busywr", 32'(bits), 32'(exp_frame(8'hED)));
    chk("busywr_done", n_done, 1);
    chk("busywr_err", n_err, 0);

    // Device stops after d3: timeout measured from the last device falling edge
    clr();
    send(8'h3C);
    dev_frame(4, 1'b0, bits, lf, lr);
    t = 0;
    while (n_err == 0 && t < TO + 500) begin @(negedge clk); t++; end
    chk("tmo_seen", n_err, 1);
    chk("tmo_delay", err_cyc - lf, 2 + FL + TO);
    chk("tmo_oe", 32'(err_oe), 0);
    chk("tmo_bits", 32'(bits[4:0]), 32'(exp_frame(8'h3C) & 11'h1F));
    chk("tmo_done", n_done, 0);
    wait_idle();
    chk("tmo_oe_after", {ps2c_oe, ps2d_oe}, 0);
    run_byte(8'h12, 1'b1);

    // Reset in the middle of DATA
    clr();
    send(8'h81);
    dev_frame(5, 1'b0, bits, lf, lr);
    chk("pre_rst_doe", 32'(ps2d_oe), 1);
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("rst_async", {ps2c_oe, ps2d_oe, busy}, 0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_pulse", n_done + n_err, 0);
    run_byte(8'hF4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
